// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   arb_state_t  : sequencer states of uart_tx_arbiter
//   UART_DATA_W  : byte width expected by uart_tx
//   rr_wrap_inc  : modulo-n increment used for round-robin pointer updates
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_t;

    // (idx + 1) mod n without a divider; correct for non-power-of-2 n.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Requester-side handshake bundle of uart_tx_arbiter.
//   req_valid [NUM_REQ]        : requester i has a byte pending
//   req_data  [NUM_REQ*DATA_W] : byte of requester i in [i*DATA_W +: DATA_W]
//   req_ready [NUM_REQ]        : one-hot accept strobe from the arbiter
// Modports:
//   master : byte producers (drive valid/data, observe ready)
//   slave  : the arbiter    (observe valid/data, drive ready)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = uart_pkg::UART_DATA_W
);
    import uart_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Purely combinational round-robin pick: returns the first set bit of req
// when scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
// Ports:
//   req    in  [NUM_REQ] : request vector
//   rr_ptr in  [PTR_W]   : highest-priority index (must be < NUM_REQ)
//   winner out [PTR_W]   : selected index (0 when nothing is requested)
//   found  out 1         : at least one request bit was set
// ---------------------------------------------------------------------------
module rr_priority_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               found
);

    // cand_idx[k] is the requester examined at scan offset k from rr_ptr.
    logic [PTR_W-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [PTR_W:0] sum;
            // One extra bit so rr_ptr + offset cannot overflow before the wrap.
            assign sum = {1'b0, rr_ptr} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ))
                                ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                : sum[PTR_W-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the smallest offset is written last and wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand_idx[k];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter/sequencer sharing one uart_tx among NUM_REQ producers.
// Accepts one byte per grant, holds it on tx_data, pulses tx_start for one
// cycle, then follows tx_busy until the frame completes before rotating.
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   req_if      slave requester handshake (req_valid/req_data/req_ready)
//   tx_start    out  single-cycle start pulse to uart_tx
//   tx_data     out  byte to uart_tx, stable from accept until back in idle
//   tx_busy     in   busy flag from uart_tx
//   grant_id    out  index of the requester owning the transmitter
//   active      out  high whenever the sequencer is not idle
//   err_timeout out  one-cycle pulse when tx_busy never acknowledged a start
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = UART_DATA_W,
    parameter int START_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    uart_tx_arbiter_if.slave           req_if,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       err_timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    arb_state_t        state_reg,       state_next;
    logic [PTR_W-1:0]  rr_ptr_reg,      rr_ptr_next;
    logic [PTR_W-1:0]  grant_id_reg,    grant_id_next;
    logic [DATA_W-1:0] tx_data_reg,     tx_data_next;
    logic [CNT_W-1:0]  cnt_reg,         cnt_next;
    logic              err_timeout_reg, err_timeout_next;

    logic [PTR_W-1:0]   winner;
    logic               found;
    logic               grant_ok;
    logic [NUM_REQ-1:0] req_ready_vec;
    logic [DATA_W-1:0]  req_bytes [NUM_REQ];
    logic [PTR_W-1:0]   ptr_after_grant;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req_if.req_valid),
        .rr_ptr (rr_ptr_reg),
        .winner (winner),
        .found  (found)
    );

    // A grant is only offered while idle with the transmitter free; rst_n
    // gates it so no handshake can complete while reset is being held.
    assign grant_ok = rst_n && (state_reg == ARB_IDLE) && !tx_busy && found;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_bytes[gi]     = req_if.req_data[gi*DATA_W +: DATA_W];
            assign req_ready_vec[gi] = grant_ok && (winner == PTR_W'(gi));
        end
    endgenerate

    assign req_if.req_ready = req_ready_vec;

    // Priority always moves to the requester after the one just served,
    // whether its frame completed or timed out.
    assign ptr_after_grant = PTR_W'(rr_wrap_inc(int'(grant_id_reg), NUM_REQ));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ARB_IDLE;
            rr_ptr_reg      <= '0;
            grant_id_reg    <= '0;
            tx_data_reg     <= '0;
            cnt_reg         <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rr_ptr_reg      <= rr_ptr_next;
            grant_id_reg    <= grant_id_next;
            tx_data_reg     <= tx_data_next;
            cnt_reg         <= cnt_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        rr_ptr_next      = rr_ptr_reg;
        grant_id_next    = grant_id_reg;
        tx_data_next     = tx_data_reg;
        cnt_next         = cnt_reg;
        err_timeout_next = 1'b0;

        unique case (state_reg)
            ARB_IDLE: begin
                if (grant_ok) begin
                    tx_data_next  = req_bytes[winner];
                    grant_id_next = winner;
                    state_next    = ARB_ISSUE;
                end
            end

            ARB_ISSUE: begin
                cnt_next   = '0;
                state_next = ARB_WAIT_BUSY;
            end

            ARB_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = ARB_WAIT_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    // The increment about to land on START_TIMEOUT ends the wait.
                    if (cnt_reg == CNT_W'(START_TIMEOUT - 1)) begin
                        err_timeout_next = 1'b1;
                        rr_ptr_next      = ptr_after_grant;
                        state_next       = ARB_IDLE;
                    end
                end
            end

            ARB_WAIT_DONE: begin
                if (!tx_busy) begin
                    rr_ptr_next = ptr_after_grant;
                    state_next  = ARB_IDLE;
                end
            end

            default: state_next = ARB_IDLE;
        endcase
    end

    // tx_start is a pure state decode, so it can only ever appear in ARB_ISSUE.
    assign tx_start    = (state_reg == ARB_ISSUE);
    assign tx_data     = tx_data_reg;
    assign grant_id    = grant_id_reg;
    assign active      = (state_reg != ARB_IDLE);
    assign err_timeout = err_timeout_reg;

endmodule
